// File: rtl/fir_pkg.sv
// Shared widths, history depth and controller state encoding for the FIR sample buffer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fir_pkg;
   localparam int DW    = 18;              // sample width
   localparam int LANES = 8;               // samples per read word, one bank each
   localparam int AW    = 11;              // row address width per bank
   localparam int IW    = AW + 3;          // sample index width
   localparam int DEPTH = LANES * (1 << AW); // history depth in samples

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_ARM   = 2'd2;
   localparam logic [1:0] ST_BUSY  = 2'd3;
endpackage

// File: rtl/fir_sample_buffer_if.sv
// Sample input, engine read port and run handshake between FIR engine side and sample buffer.
// Latency: n/a (wiring only).
// Backpressure: sample_ready gates sample_valid; fir_done releases the next sample.
interface fir_sample_buffer_if;
   import fir_pkg::*;

   logic signed [DW-1:0]       sample_in;
   logic                       sample_valid;
   logic                       sample_ready;
   logic [AW-1:0]              addr_data;
   logic [LANES*DW-1:0]        datain;
   logic                       datain_ready;
   logic                       fir_done;

   modport master (
      output sample_in, sample_valid, addr_data, fir_done,
      input  sample_ready, datain, datain_ready
   );

   modport slave (
      input  sample_in, sample_valid, addr_data, fir_done,
      output sample_ready, datain, datain_ready
   );
endinterface

// File: rtl/fir_sample_bank.sv
// One history bank: 2048x18 simple dual-port RAM, one write port, one read port.
// Latency: read data registered, valid one clock after rd_row is sampled.
// Backpressure: none; accepts a write and a read every cycle.
module fir_sample_bank
   import fir_pkg::*;
(
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] wr_row,
   input  logic [DW-1:0] wr_dat,
   input  logic [AW-1:0] rd_row,
   output logic [DW-1:0] rd_dat
);
   logic [DW-1:0] mem [1 << AW];

   // Write port plus synchronous read (read-before-write on address collision).
   always_ff @(posedge clock) begin
      if (we) begin
         mem[wr_row] <= wr_dat;
      end
      rd_dat <= mem[rd_row];
   end
endmodule

// File: rtl/fir_sample_buffer.sv
// 16384-sample circular history in 8 banks; serves 8 consecutive past samples per read, newest first.
// Latency: addr_data sampled at edge t appears on datain after edge t+1, one read per cycle.
// Backpressure: one sample per FIR run; sample_ready only in IDLE, reopened by fir_done.
module fir_sample_buffer
   import fir_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   fir_sample_buffer_if.slave  bus
);
   logic [1:0]          state;
   logic [AW-1:0]       clr_row;
   logic [IW-1:0]       wp;
   logic [IW-1:0]       newest;
   logic                xfer;

   logic [LANES-1:0]    wr_en;
   logic [AW-1:0]       wr_row;
   logic [DW-1:0]       wr_dat;

   logic [IW-1:0]       base;
   logic [AW-1:0]       rd_row [LANES];
   logic [DW-1:0]       rd_q   [LANES];
   logic [2:0]          base_lo_q;
   logic [2:0]          sel;
   logic [LANES*DW-1:0] datain_nxt;
   logic [LANES*DW-1:0] datain_q;

   assign xfer             = (state == ST_IDLE) && bus.sample_valid;
   assign bus.sample_ready = (state == ST_IDLE);
   assign bus.datain_ready = (state == ST_ARM);
   assign bus.datain       = datain_q;

   // Controller: clear all rows after reset, then one sample per engine run.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_CLEAR;
         clr_row <= '0;
         wp      <= '0;
         newest  <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_row <= clr_row + 1'b1;
               if (clr_row == AW'((1 << AW) - 1)) state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (bus.sample_valid) begin
                  newest <= wp;
                  wp     <= wp + 1'b1;
                  state  <= ST_ARM;
               end
            end
            ST_ARM:  state <= ST_BUSY;
            default: if (bus.fir_done) state <= ST_IDLE;
         endcase
      end
   end

   // Write steering: every bank zeroed during CLEAR, otherwise bank wp[2:0] on a transfer.
   always_comb begin
      wr_en  = '0;
      wr_row = wp[IW-1:3];
      wr_dat = bus.sample_in;
      if (state == ST_CLEAR) begin
         wr_en  = '1;
         wr_row = clr_row;
         wr_dat = '0;
      end else if (xfer) begin
         wr_en[wp[2:0]] = 1'b1;
      end
   end

   // Row select: banks above base[2:0] hold the older half of the word, one row back.
   always_comb begin
      base = newest - {bus.addr_data, 3'b000};
      for (int b = 0; b < LANES; b++) begin
         rd_row[b] = (3'(b) <= base[2:0]) ? base[IW-1:3] : base[IW-1:3] - 1'b1;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_bank
      fir_sample_bank u_bank (
         .clock  (clock),
         .we     (wr_en[g]),
         .wr_row (wr_row),
         .wr_dat (wr_dat),
         .rd_row (rd_row[g]),
         .rd_dat (rd_q[g])
      );
   end

   // Carry base[2:0] alongside the RAM read so the rotation matches the returned row data.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) base_lo_q <= '0;
      else        base_lo_q <= base[2:0];
   end

   // Lane rotation: lane j takes bank (base[2:0] - j) mod 8, lane 0 in the top bits.
   always_comb begin
      datain_nxt = '0;
      sel        = '0;
      for (int j = 0; j < LANES; j++) begin
         sel = base_lo_q - 3'(j);
         datain_nxt[(LANES-1-j)*DW +: DW] = rd_q[sel];
      end
   end

   // Output register, cleared by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) datain_q <= '0;
      else        datain_q <= datain_nxt;
   end
endmodule

// File: tb/tb_fir_sample_buffer.sv
// Directed bench for fir_sample_buffer: clear, impulse, ramp, wrap, backpressure, reset mid-run.
// Latency: reads checked two edges after addr_data is driven.
// Backpressure: samples offered with sample_valid and released with fir_done pulses.
module tb_fir_sample_buffer;
   logic clock;
   logic reset;
   int   n_assert;
   int   n_fail;

   fir_sample_buffer_if bus ();

   fir_sample_buffer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [143:0] put(input logic [143:0] w, input int j, input logic [17:0] v);
      logic [143:0] r;
      r = w;
      r[(7-j)*18 +: 18] = v;
      return r;
   endfunction

   // Lane j holds value (top - j), or 0 where that index was never written.
   function automatic logic [143:0] ramp_word(input int top);
      logic [143:0] r;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         if (top - j >= 0) r = put(r, j, 18'(top - j));
      end
      return r;
   endfunction

   task automatic read_word(input int k, output logic [143:0] w);
      bus.addr_data = 11'(k);
      tick();
      tick();
      w = bus.datain;
   endtask

   // Count 2048 CLEAR cycles after release; sample_ready must rise exactly on the last one.
   task automatic clear_wait(input string tag);
      for (int c = 1; c <= 2048; c++) begin
         tick();
         if (c < 2048) check({tag, "_ready_low"}, {143'b0, bus.sample_ready}, 144'd0);
         else          check({tag, "_ready_rise"}, {143'b0, bus.sample_ready}, 144'd1);
      end
   endtask

   task automatic send_sample(input logic [17:0] v, input bit chk);
      int n;
      n = 0;
      bus.sample_in    = v;
      bus.sample_valid = 1'b1;
      while (!bus.sample_ready && n < 5000) begin
         tick();
         n++;
      end
      if (n >= 5000) check("send_timeout", {143'b0, bus.sample_ready}, 144'd1);
      tick();
      bus.sample_valid = 1'b0;
      if (chk) check("arm_pulse", {143'b0, bus.datain_ready}, 144'd1);
      tick();
      if (chk) check("busy_pulse_low", {143'b0, bus.datain_ready}, 144'd0);
      if (chk) check("busy_not_ready", {143'b0, bus.sample_ready}, 144'd0);
      bus.fir_done = 1'b1;
      tick();
      bus.fir_done = 1'b0;
   endtask

   initial begin
      logic [143:0] w;
      logic [143:0] e;
      int xfers;
      int pulses;
      n_assert = 0;
      n_fail   = 0;
      reset            = 1'b0;
      bus.sample_in    = '0;
      bus.sample_valid = 1'b0;
      bus.addr_data    = '0;
      bus.fir_done     = 1'b0;

      // Reset values
      #1;
      check("rst_ready", {143'b0, bus.sample_ready}, 144'd0);
      check("rst_dready", {143'b0, bus.datain_ready}, 144'd0);
      check("rst_datain", bus.datain, 144'd0);
      tick(); tick(); tick();
      reset = 1'b1;
      clear_wait("clr0");

      // Whole history reads zero after clear
      for (int k = 0; k < 2048; k++) begin
         read_word(k, w);
         check("zero_read", w, 144'd0);
      end

      // fir_done outside BUSY is ignored: still ready in IDLE
      bus.fir_done = 1'b1;
      tick();
      bus.fir_done = 1'b0;
      check("done_ignored", {143'b0, bus.sample_ready}, 144'd1);

      // Impulse
      send_sample(18'h1FFFF, 1'b1);
      read_word(0, w);
      check("imp_k0", w, {18'h1FFFF, 126'b0});
      for (int i = 0; i < 9; i++) send_sample(18'h0, 1'b0);
      read_word(1, w);
      e = put(144'd0, 1, 18'h1FFFF);
      check("imp_k1", w, e);
      read_word(0, w);
      check("imp_k0_late", w, 144'd0);

      // Ramp 0..19 on fresh history, reads pipelined back to back
      reset = 1'b0;
      tick(); tick();
      reset = 1'b1;
      clear_wait("clr1");
      for (int v = 0; v < 20; v++) send_sample(18'(v), 1'b0);
      bus.addr_data = 11'd0;
      tick();
      bus.addr_data = 11'd1;
      tick();
      check("ramp_k0", bus.datain, ramp_word(19));
      bus.addr_data = 11'd2;
      tick();
      check("ramp_k1", bus.datain, ramp_word(11));
      tick();
      check("ramp_k2", bus.datain, ramp_word(3));

      // Continue ramp to 16390 samples total: newest index 5, value 16389
      for (int v = 20; v < 16390; v++) send_sample(18'(v), 1'b0);
      read_word(0, w);
      check("wrap_k0", w, ramp_word(16389));
      read_word(1, w);
      check("wrap_k1", w, ramp_word(16381));
      read_word(2047, w);
      check("wrap_k2047", w, ramp_word(13));

      // Backpressure: valid held high, four transfers released by three fir_done pulses
      xfers  = 0;
      pulses = 0;
      bus.sample_in    = 18'h2AAAA;
      bus.sample_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         bus.fir_done = (c == 10 || c == 20 || c == 30);
         if (bus.sample_ready) xfers++;
         if (bus.datain_ready) pulses++;
         tick();
      end
      bus.sample_valid = 1'b0;
      bus.fir_done     = 1'b0;
      check("bp_xfers", 144'(xfers), 144'd4);
      check("bp_pulses", 144'(pulses), 144'd4);
      check("bp_busy", {143'b0, bus.sample_ready}, 144'd0);
      read_word(0, w);
      e = ramp_word(16393);
      for (int j = 0; j < 4; j++) e = put(e, j, 18'h2AAAA);
      check("bp_k0", w, e);

      // Reset asserted mid-BUSY: outputs drop immediately, then a full re-clear
      check("pre_rst_busy", {143'b0, bus.sample_ready}, 144'd0);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_ready", {143'b0, bus.sample_ready}, 144'd0);
      check("midrst_dready", {143'b0, bus.datain_ready}, 144'd0);
      check("midrst_datain", bus.datain, 144'd0);
      @(negedge clock);
      tick();
      reset = 1'b1;
      clear_wait("clr2");
      read_word(0, w);
      check("post_k0", w, 144'd0);
      read_word(1, w);
      check("post_k1", w, 144'd0);
      read_word(2047, w);
      check("post_k2047", w, 144'd0);
      send_sample(18'h00005, 1'b1);
      read_word(0, w);
      check("post_first", w, {18'h00005, 126'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fir_sample_buffer.md
# fir_sample_buffer

Circular history buffer sitting directly upstream of the 8-lane FIR MAC engine. It accepts one 18-bit input sample per filter run and stores the last 16384 samples in eight 2048-deep banks. It then serves the engine's `addr_data` reads as 144-bit words of eight consecutive past samples, newest first. It also generates the `datain_ready` start pulse and holds off new samples until the engine reports completion.

## Interface
- `DW`, 18, sample width
- `LANES`, 8, samples per read word / number of banks
- `AW`, 11, row address width (2048 rows per bank; history depth = 16384)
- `clock`  in  1  single clock domain, rising edge
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `sample_in`  in  18  signed input sample
- `sample_valid`  in  1  sample_in valid
- `sample_ready`  out  1  buffer can accept a sample this cycle
- `addr_data`  in  11  engine read index k (0..2047)
- `datain`  out  144  lanes 0..7 at [143:126] .. [17:0], lane 0 newest
- `datain_ready`  out  1  one-cycle pulse: new sample stored, start FIR run
- `fir_done`  in  1  engine `dataout_ready` pulse; run finished

## Operation
- Sample index space is 14 bits. `wp` is the next write index. `newest` is the index of the last written sample. Both reset to 0.
- Sample index i is stored in bank i[2:0] at row i[13:3].
- Read mapping: for k = `addr_data`, lane j returns sample (newest − 8k − j) mod 16384.
  - Let base = newest − 8k (14-bit wrap).
  - Bank b reads row base[13:3] if b ≤ base[2:0], else base[13:3] − 1 (mod 2048).
  - Lane j takes bank (base[2:0] − j) mod 8.
- FSM states: CLEAR, IDLE, ARM, BUSY.
  - CLEAR: entered on reset release. A row counter runs 0..2047 and writes 0 to all 8 banks per cycle. After row 2047, go to IDLE. `sample_ready` is 0.
  - IDLE: `sample_ready` = 1. On `sample_valid`, write `sample_in` at index `wp`, set `newest` ← `wp` and `wp` ← `wp` + 1 (16383 wraps to 0), then go to ARM.
  - ARM: `datain_ready` = 1 for exactly this cycle, then go to BUSY.
  - BUSY: `sample_ready` = 0. On `fir_done`, go to IDLE. `fir_done` in any other state is ignored.
- Never-written history reads as 0, guaranteed by CLEAR.
- Reads are legal in IDLE, ARM and BUSY. `datain` during CLEAR is don't-care.
- Asserting `reset` at any point, including mid-BUSY, immediately forces CLEAR with `wp` = `newest` = 0 and all outputs at reset values. Memory is then re-cleared.

## Timing
- Reset values: `sample_ready` = 0, `datain_ready` = 0, `datain` = 0 (output register cleared).
- CLEAR lasts exactly 2048 cycles after reset deassertion. `sample_ready` first rises on cycle 2048.
- Sample handshake: a transfer occurs on a clock edge where `sample_valid` & `sample_ready`.
- `datain_ready` is high in the cycle immediately after the transfer edge.
- Read latency is 1 cycle: `addr_data` sampled at edge t appears on `datain` after edge t+1.
  - Bank RAMs are synchronous-read.
  - base[2:0] is registered alongside the read so the lane rotation stays aligned with the RAM data.
- Sustained reads: one new `addr_data` per cycle, fully pipelined.
- Minimum spacing between accepted samples: 3 cycles (IDLE→ARM→BUSY→`fir_done`→IDLE). In practice this is bounded by the engine run length.

## Structure
- Shared package `fir_pkg`: `DW`, `LANES`, `AW`, history depth constant, and the FSM state encoding.
- Sub-module `fir_sample_bank`: simple dual-port RAM, 2048×18, one write port and one synchronous read port. Instantiated 8 times.
- The row-select and rotation logic stays in the top module.

## Test plan
- Reset release: `sample_ready` stays 0 for 2048 cycles, then rises. Reading k = 0..2047 returns all-zero words.
- Impulse: write 18'h1FFFF, then zeros. After the 1st sample, k = 0 gives lane 0 = 1FFFF and lanes 1–7 = 0. After 10 samples total, k = 1 gives lane 1 = 1FFFF.
- Ramp 0,1,2,… for 20 samples (newest = 19): k = 0 gives lanes 19..12, k = 1 gives 11..4, k = 2 gives 3,2,1,0,0,0,0,0.
- Wrap: write 16390 ramp samples (values mod 2^18). k = 0 lanes equal the last 8 written. k = 2047 lane 7 equals sample (newest − 16383) mod 16384, confirming the row −1 wrap across row 0.
- Backpressure: hold `sample_valid` = 1 continuously. Exactly one transfer occurs per `fir_done`, and `datain_ready` pulses once per transfer.
- Reset asserted mid-BUSY: outputs drop immediately. After release, CLEAR repeats (2048 cycles) and the previously written data reads back as 0.
